// File: rtl/fifo_ctrl_4x8.sv
// 4-entry FIFO controller in front of a single-port 4x8 RAM, with a registered head byte.
// One RAM access per cycle; flush beats refill, which beats write.
module fifo_ctrl_4x8 #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_read_write,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_clear,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int             DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH  = DEPTH_I[ADDR_W:0];

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              refill;
    logic              pop;

    // Head register takes the next RAM byte whenever it is empty or being consumed.
    assign refill = (count != '0) && (!out_valid || out_ready);
    assign pop    = out_valid && out_ready;

    always_comb begin
        state = S_IDLE;
        if (flush)                   state = S_FLUSH;
        else if (refill)             state = S_READ;
        else if (in_valid && !full)  state = S_WRITE;
    end

    assign full           = (count == DEPTH);
    assign empty          = (count == '0) && !out_valid;
    assign in_ready       = !flush && !full && !refill;
    assign ram_address    = (state == S_WRITE) ? wr_ptr : rd_ptr;
    assign ram_read_write = (state == S_WRITE);
    assign ram_data       = in_data;
    assign ram_clear      = (state == S_FLUSH);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_FLUSH: begin
                    wr_ptr    <= '0;
                    rd_ptr    <= '0;
                    count     <= '0;
                    out_valid <= 1'b0;
                end
                S_READ: begin
                    out_data  <= ram_rdata;
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + 1'b1;
                    count     <= count - 1'b1;
                end
                S_WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    count  <= count + 1'b1;
                    // RAM was empty, so a consumed head cannot be refilled this cycle.
                    if (pop) out_valid <= 1'b0;
                end
                default: begin
                    if (pop) out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_4x8.sv
// Bench for fifo_ctrl_4x8: RAM model, queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized soak with flushes.
module tb_fifo_ctrl_4x8;

    logic       clock;
    logic       clear;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic [1:0] ram_address;
    logic       ram_read_write;
    logic [7:0] ram_data;
    logic       ram_clear;
    logic [7:0] ram_rdata;

    fifo_ctrl_4x8 #(.DATA_W(8), .ADDR_W(2)) dut (
        .clock(clock), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count), .full(full), .empty(empty),
        .ram_address(ram_address), .ram_read_write(ram_read_write),
        .ram_data(ram_data), .ram_clear(ram_clear), .ram_rdata(ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 4x8 RAM: synchronous write/clear, combinational read.
    logic [7:0] mem [0:3];
    always @(posedge clock) begin
        if (ram_clear) begin
            for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
        end else if (ram_read_write) begin
            mem[ram_address] <= ram_data;
        end
    end
    assign ram_rdata = mem[ram_address];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes stored in RAM as a queue, plus the head byte.
    logic [7:0] mq[$];
    logic       mhv = 1'b0;
    logic [7:0] mhd = 8'h00;

    initial begin
        forever begin
            @(negedge clock);
            if (!clear) begin
                mq.delete();
                mhv = 1'b0;
                mhd = 8'h00;
            end else begin
                automatic int   sz     = mq.size();
                automatic logic e_refl = (sz != 0) && (!mhv || out_ready);
                automatic logic e_wr   = !flush && !e_refl && in_valid && (sz < 4);
                chk("count", 32'(count), 32'(sz));
                chk("full", 32'(full), 32'(sz == 4));
                chk("empty", 32'(empty), 32'(sz == 0 && !mhv));
                chk("out_valid", 32'(out_valid), 32'(mhv));
                if (mhv) chk("out_data", 32'(out_data), 32'(mhd));
                chk("in_ready", 32'(in_ready), 32'(!flush && sz < 4 && !e_refl));
                chk("ram_read_write", 32'(ram_read_write), 32'(e_wr));
                chk("ram_clear", 32'(ram_clear), 32'(flush));
                chk("ram_data", 32'(ram_data), 32'(in_data));
                // Advance the model with the inputs the DUT samples at the next rising edge.
                if (flush) begin
                    mq.delete();
                    mhv = 1'b0;
                end else if (e_refl) begin
                    mhd = mq.pop_front();
                    mhv = 1'b1;
                end else begin
                    if (in_valid && sz < 4) mq.push_back(in_data);
                    if (mhv && out_ready) mhv = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one byte and hold it until accepted; returns just after the accepting edge.
    task automatic push(input logic [7:0] d);
        automatic bit done = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clock);
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("push_timeout", 32'(0), 32'(1));
    endtask

    logic [7:0] got[$];

    initial begin
        clear = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick(); tick();
        clear = 1'b1;

        // Reset mid-stream after three pushes.
        push(8'hC1); push(8'hC2); push(8'hC3);
        clear = 1'b0;
        @(negedge clock);
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(8'h00));
        tick();
        clear = 1'b1;
        @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_full", 32'(full), 32'(0));
        tick();

        // Fill to capacity with the consumer stalled.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        in_valid = 1'b1; in_data = 8'h66;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("fill_out_data", 32'(out_data), 32'(8'h11));
            chk("fill_out_valid", 32'(out_valid), 32'(1));
            chk("fill_count", 32'(count), 32'(4));
            chk("fill_full", 32'(full), 32'(1));
            chk("fill_in_ready", 32'(in_ready), 32'(0));
            tick();
        end
        in_valid = 1'b0;

        // Drain at full rate: one byte per cycle, no writes.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("drain_valid", 32'(out_valid), 32'(1));
            chk("drain_data", 32'(out_data), 32'((i + 1) * 8'h11));
            chk("drain_no_write", 32'(ram_read_write), 32'(0));
            tick();
        end
        @(negedge clock);
        chk("drain_empty", 32'(empty), 32'(1));
        tick();

        // Interleaved pushes/pops of 0x01..0x0C with random backpressure.
        begin
            automatic int  widx = 1;
            automatic bit  acc;
            in_valid = 1'b1; in_data = 8'h01; out_ready = 1'b0;
            for (int c = 0; c < 600 && got.size() < 12; c++) begin
                @(negedge clock);
                acc = in_valid && in_ready;
                if (out_valid && out_ready) got.push_back(out_data);
                if (got.size() < 12) begin
                    tick();
                    if (acc) widx++;
                    if (acc || !in_valid) begin
                        in_valid = (widx <= 12) && ($urandom_range(0, 3) != 0);
                        in_data  = 8'(widx);
                    end
                    out_ready = $urandom_range(0, 1) == 1;
                end
            end
            tick();
            in_valid = 1'b0; out_ready = 1'b0;
            chk("wrap_count", 32'(got.size()), 32'(12));
            for (int i = 0; i < got.size(); i++) chk("wrap_order", 32'(got[i]), 32'(i + 1));
        end

        // Flush while full, then a single byte through the emptied FIFO.
        push(8'h81); push(8'h82); push(8'h83); push(8'h84); push(8'h85);
        @(negedge clock);
        chk("flush_pre_full", 32'(full), 32'(1));
        tick();
        flush = 1'b1;
        @(negedge clock);
        chk("flush_ram_clear", 32'(ram_clear), 32'(1));
        chk("flush_in_ready", 32'(in_ready), 32'(0));
        tick();
        flush = 1'b0;
        @(negedge clock);
        chk("flush_count", 32'(count), 32'(0));
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_clear_off", 32'(ram_clear), 32'(0));
        tick();
        out_ready = 1'b1;
        push(8'hA5);
        @(negedge clock);
        chk("lat_refill_cycle", 32'(out_valid), 32'(0));
        tick();
        @(negedge clock);
        chk("lat_out_valid", 32'(out_valid), 32'(1));
        chk("lat_out_data", 32'(out_data), 32'(8'hA5));
        tick();
        out_ready = 1'b0;

        // Write request colliding with a refill.
        push(8'h5A);
        in_valid = 1'b1; in_data = 8'h5B;
        @(negedge clock);
        chk("coll_in_ready", 32'(in_ready), 32'(0));
        chk("coll_read", 32'(ram_read_write), 32'(0));
        tick();
        @(negedge clock);
        chk("coll_retry_ready", 32'(in_ready), 32'(1));
        chk("coll_retry_write", 32'(ram_read_write), 32'(1));
        chk("coll_head", 32'(out_data), 32'(8'h5A));
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("coll_out0", 32'(out_data), 32'(8'h5A));
        tick();
        @(negedge clock);
        chk("coll_out1", 32'(out_data), 32'(8'h5B));
        chk("coll_out1_valid", 32'(out_valid), 32'(1));
        tick();
        out_ready = 1'b0;
        @(negedge clock);
        chk("coll_empty", 32'(empty), 32'(1));
        tick();

        // Randomized soak; the model process checks every cycle.
        begin
            automatic int rdy_pct = 50;
            for (int c = 0; c < 2000; c++) begin
                if (c % 100 == 0) rdy_pct = $urandom_range(10, 90);
                flush     = ($urandom_range(0, 59) == 0);
                in_valid  = ($urandom_range(0, 2) != 0);
                in_data   = 8'($urandom);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                tick();
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        @(negedge clock);
        chk("final_empty", 32'(empty), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
